// File: rtl/ram_sweep_ctrl.sv
// Write/read sweep controller around an inferred single-port RAM.
// A write sweep fills every word with its address pattern; a read sweep dwells on each word, and can be paused and resumed.
module ram_sweep_ctrl #(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 256,
  parameter logic [23:0] HOLD_MAX = 24'd9_999_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_flag,
  input  logic              rd_flag,
  input  logic              mode,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        state_out,
  output logic              wr_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [23:0]       CNT_ZERO  = 24'd0;
  localparam logic [23:0]       CNT_ONE   = 24'd1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              we_s, re_s;
  logic [DATA_W-1:0] wdata_s;
  logic [ADDR_W-1:0] addr_inc_s;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_done_d  = 1'b0;
    we_s       = 1'b0;
    re_s       = 1'b0;
    wdata_s    = mode ? ~DATA_W'(addr_q) : DATA_W'(addr_q);
    addr_inc_s = (addr_q == ADDR_LAST) ? ADDR_ZERO : addr_q + ADDR_ONE;

    case (state_q)
      ST_IDLE: begin
        if (wr_flag) begin
          state_d = ST_WRITE;
          addr_d  = ADDR_ZERO;
          cnt_d   = CNT_ZERO;
        end else if (rd_flag) begin
          state_d = ST_READ;
          addr_d  = ADDR_ZERO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // A write sweep cannot be interrupted by either key.
      ST_WRITE: begin
        we_s = 1'b1;
        if (addr_q == ADDR_LAST) begin
          state_d   = ST_IDLE;
          addr_d    = ADDR_ZERO;
          wr_done_d = 1'b1;
        end else begin
          addr_d = addr_inc_s;
        end
      end
      ST_READ: begin
        re_s = 1'b1;
        if (wr_flag) begin
          state_d = ST_WRITE;
          addr_d  = ADDR_ZERO;
          cnt_d   = CNT_ZERO;
        end else if (rd_flag) begin
          state_d = ST_PAUSE;
        end else if (cnt_q == HOLD_MAX) begin
          cnt_d  = CNT_ZERO;
          addr_d = addr_inc_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PAUSE: begin
        re_s = 1'b1;
        if (wr_flag) begin
          state_d = ST_WRITE;
          addr_d  = ADDR_ZERO;
          cnt_d   = CNT_ZERO;
        end else if (rd_flag) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = ADDR_ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase

    rd_valid_d = re_s && ((state_d == ST_READ) || (state_d == ST_PAUSE));
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_ZERO;
      cnt_q      <= CNT_ZERO;
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      if (re_s) begin
        rd_data_q <= mem_q[addr_q];
      end
    end
  end

  // RAM contents survive reset; only the write in the reset cycle itself is suppressed.
  always_ff @(posedge sys_clk) begin
    if (we_s && !sys_rst) begin
      mem_q[addr_q] <= wdata_s;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign addr_out  = addr_q;
  assign state_out = state_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Directed and randomized bench for ram_sweep_ctrl with a small DEPTH=5, HOLD_MAX=2 instance.
// Expected outputs come from a sweep model that derives the read address from elapsed dwell ticks.
module tb_ram_sweep_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 5;
  localparam int HOLD   = 2;
  localparam int SWEEP  = DEPTH * (HOLD + 1);

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              wr_flag = 1'b0;
  logic              rd_flag = 1'b0;
  logic              mode    = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] addr_out;
  logic [1:0]        state_out;
  logic              wr_done;

  ram_sweep_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .HOLD_MAX(24'd2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wr_flag  (wr_flag),
    .rd_flag  (rd_flag),
    .mode     (mode),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .addr_out (addr_out),
    .state_out(state_out),
    .wr_done  (wr_done)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Model: state 0..3, writes completed in this sweep, dwell ticks since read start.
  int         m_state = 0;
  int         m_wk    = 0;
  int         m_ticks = 0;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_rd_data  = 8'h00;
  logic       m_rd_valid = 1'b0;
  logic       m_wr_done  = 1'b0;

  function automatic int exp_addr();
    case (m_state)
      1:       return m_wk;
      2, 3:    return (m_ticks / (HOLD + 1)) % DEPTH;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic md, input logic rs);
    int         pre;
    int         a_pre;
    logic [7:0] v;
    sys_rst = rs;
    wr_flag = w;
    rd_flag = r;
    mode    = md;
    @(posedge sys_clk);
    pre   = m_state;
    a_pre = exp_addr();
    if (rs) begin
      m_state    = 0;
      m_wk       = 0;
      m_ticks    = 0;
      m_rd_data  = 8'h00;
      m_rd_valid = 1'b0;
      m_wr_done  = 1'b0;
    end else begin
      m_wr_done = 1'b0;
      if (pre >= 2) m_rd_data = m_mem[a_pre];
      case (pre)
        0: begin
          if (w) begin m_state = 1; m_wk = 0; end
          else if (r) begin m_state = 2; m_ticks = 0; end
        end
        1: begin
          v = 8'(m_wk);
          if (md) v = ~v;
          m_mem[m_wk] = v;
          m_wk++;
          if (m_wk == DEPTH) begin
            m_state   = 0;
            m_wk      = 0;
            m_wr_done = 1'b1;
          end
        end
        2: begin
          if (w) begin m_state = 1; m_wk = 0; end
          else if (r) m_state = 3;
          else m_ticks++;
        end
        3: begin
          if (w) begin m_state = 1; m_wk = 0; end
          else if (r) m_state = 2;
        end
        default: ;
      endcase
      m_rd_valid = (pre >= 2) && (m_state >= 2);
    end
    #1;
    check("state_out", 32'(state_out), 32'(m_state));
    check("addr_out",  32'(addr_out),  32'(exp_addr()));
    check("rd_data",   32'(rd_data),   32'(m_rd_data));
    check("rd_valid",  32'(rd_valid),  32'(m_rd_valid));
    check("wr_done",   32'(wr_done),   32'(m_wr_done));
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    @(negedge sys_clk);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);

    // Incrementing pattern; keys pressed mid-sweep must be ignored.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle(2);

    // Full read sweep with wrap back to address 0.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(SWEEP + 1);

    // Pause at address 2, dwell count 1, then resume.
    for (int g = 0; g < 2 * SWEEP && (m_ticks % SWEEP) != 7; g++) idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Both keys in READ: write wins; inverted pattern.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(SWEEP + 2);

    // Abort a write sweep with reset after three words.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(SWEEP + 1);

    // Randomized key traffic.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
